dispense_sequencer: RTL

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/vending_pkg.sv | 46 ++++
 rtl/dispense_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: drink codes, dispense sequencer state
// encoding and small helpers used by the sequencer and the vending top.
package vending_pkg;

  typedef enum logic [1:0] {
    BLACK       = 2'd0,
    CREAM       = 2'd1,
    CREAM_SUGAR = 2'd2,
    ILLEGAL     = 2'd3
  } drink_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COFFEE = 3'd1,
    ST_WATER  = 3'd2,
    ST_CREAM  = 3'd3,
    ST_SUGAR  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic coffee;
    logic water;
    logic cream;
    logic sugar;
  } valves_t;

  // The timer counts down to zero, so a T-cycle phase loads T-1.
  function automatic logic [3:0] load_count(input int unsigned cycles);
    return 4'(cycles - 1);
  endfunction

  function automatic valves_t valves_for(input state_t s);
    valves_t v;
    v = '0;
    case (s)
      ST_COFFEE: v.coffee = 1'b1;
      ST_WATER:  v.water  = 1'b1;
      ST_CREAM:  v.cream  = 1'b1;
      ST_SUGAR:  v.sugar  = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dispense_sequencer.sv
// Drink dispense sequencer: opens one valve at a time for a fixed number of
// cycles, in the order dictated by the latched drink code.
module dispense_sequencer
  import vending_pkg::*;
#(
  parameter int unsigned T_COFFEE = 4,
  parameter int unsigned T_WATER  = 6,
  parameter int unsigned T_CREAM  = 2,
  parameter int unsigned T_SUGAR  = 2
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Req_Valid,
  input  logic [1:0] Req_Type,
  output logic       Req_Ready,
  input  logic       Abort,
  output logic       Coffee,
  output logic       Water,
  output logic       Cream,
  output logic       Sugar,
  output logic       Done,
  output logic       Err,
  output logic       Aborted,
  output logic [7:0] Served
);

  state_t     state;
  state_t     after_state;
  drink_t     drink;
  valves_t    valves;
  logic [3:0] cnt;
  logic [3:0] after_load;

  assign Req_Ready = (state == ST_IDLE);
  assign Coffee    = valves.coffee;
  assign Water     = valves.water;
  assign Cream     = valves.cream;
  assign Sugar     = valves.sugar;

  // Where the current dispensing phase goes once its timer runs out.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    after_state = ST_DONE;
    case (state)
      ST_COFFEE: after_state = ST_WATER;
      ST_WATER:  after_state = (drink == BLACK) ? ST_DONE : ST_CREAM;
      ST_CREAM:  after_state = (drink == CREAM) ? ST_DONE : ST_SUGAR;
      default:   after_state = ST_DONE;
    endcase
  end

  always_comb begin
    after_load = 4'd0;
    case (after_state)
      ST_WATER: after_load = load_count(T_WATER);
      ST_CREAM: after_load = load_count(T_CREAM);
      ST_SUGAR: after_load = load_count(T_SUGAR);
      default:  after_load = 4'd0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears every flop, there is no memory here.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      drink   <= BLACK;
      cnt     <= 4'd0;
      valves  <= '0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      Aborted <= 1'b0;
      Served  <= 8'd0;
    end else begin
      Done    <= 1'b0;
      Err     <= 1'b0;
      Aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req_Valid && !Abort) begin
            if (drink_t'(Req_Type) == ILLEGAL) begin
              Err <= 1'b1;
            end else begin
              drink  <= drink_t'(Req_Type);
              state  <= ST_COFFEE;
              cnt    <= load_count(T_COFFEE);
              valves <= valves_for(ST_COFFEE);
            end
          end
        end
        ST_COFFEE, ST_WATER, ST_CREAM, ST_SUGAR: begin
          if (Abort) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            valves  <= '0;
            Aborted <= 1'b1;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= after_state;
            cnt    <= after_load;
            valves <= valves_for(after_state);
            if (after_state == ST_DONE) begin
              Done   <= 1'b1;
              Served <= Served + 8'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state  <= ST_IDLE;
          valves <= '0;
        end
      endcase
    end
  end

endmodule
